mem_access: RTL and testbench

- MEM stage plus MEM/WB pipeline register of the rv32i pipeline.
- Accepts one instruction per handshake from EX/MEM. Loads and stores go to data memory over a variable-latency req/ack bus, with byte-enable generation and load alignment/sign-extension.
- Presents registered mem_to_reg, rd, alu_result, reg_web and mem_rdata to the combinational writeback stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM stage plus MEM/WB pipeline register of the rv32i pipeline.
// Loads/stores use a variable-latency req/ack data bus. Byte enables and store
// lane replication are generated here, and loads are aligned and extended.
// The upstream stage is stalled while a bus transaction is outstanding.
// Optional feature macro: MEM_MISALIGN_CHK_EN. When it is defined, misaligned
// halfword/word accesses retire without a bus request, and wb_misalign is set.
module mem_access #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mem_read,
    input  logic                   in_mem_write,
    input  logic [2:0]             in_funct3,
    input  logic [DATA_WIDTH-1:0]  in_alu_result,
    input  logic [DATA_WIDTH-1:0]  in_store_data,
    input  logic [RADDR_WIDTH-1:0] in_rd,
    input  logic                   in_reg_web,
    input  logic                   in_mem_to_reg,
    input  logic                   flush,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DATA_WIDTH-1:0]  dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [DATA_WIDTH-1:0]  dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [DATA_WIDTH-1:0]  dmem_rdata,
    output logic                   wb_valid,
    output logic                   wb_mem_to_reg,
    output logic [RADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]  wb_alu_result,
    output logic                   wb_reg_web,
    output logic [DATA_WIDTH-1:0]  wb_mem_rdata
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic                   wb_misalign
`endif
);

    localparam int unsigned BE_W = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e                 state_q,       state_d;
    logic                   req_q,         req_d;
    logic                   we_q,          we_d;
    logic [DATA_WIDTH-1:0]  addr_q,        addr_d;
    logic [BE_W-1:0]        be_q,          be_d;
    logic [DATA_WIDTH-1:0]  wdata_q,       wdata_d;
    logic [2:0]             f3_q,          f3_d;
    logic [DATA_WIDTH-1:0]  op_alu_q,      op_alu_d;
    logic [RADDR_WIDTH-1:0] op_rd_q,       op_rd_d;
    logic                   op_web_q,      op_web_d;
    logic                   op_m2r_q,      op_m2r_d;
    logic                   kill_q,        kill_d;
    logic                   wb_valid_q,    wb_valid_d;
    logic                   wb_m2r_q,      wb_m2r_d;
    logic [RADDR_WIDTH-1:0] wb_rd_q,       wb_rd_d;
    logic [DATA_WIDTH-1:0]  wb_alu_q,      wb_alu_d;
    logic                   wb_web_q,      wb_web_d;
    logic [DATA_WIDTH-1:0]  wb_rdata_q,    wb_rdata_d;
`ifdef MEM_MISALIGN_CHK_EN
    logic                   wb_mis_q,      wb_mis_d;
`endif

    logic                   mem_op;
    logic                   misalign;
    logic [1:0]             in_lane;
    logic [BE_W-1:0]        st_be;
    logic [DATA_WIDTH-1:0]  st_wdata;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic                   ld_sign;
    logic [DATA_WIDTH-1:0]  ld_data;

    assign in_lane  = in_alu_result[1:0];
    assign mem_op   = in_mem_read | in_mem_write;
    assign in_ready = (state_q == S_IDLE);

    // Misaligned access detection (constant 0 without the check feature)
`ifdef MEM_MISALIGN_CHK_EN
    logic is_half;
    always_comb begin
        is_half  = in_mem_write ? (in_funct3 == 3'b001) : (in_funct3[1:0] == 2'b01);
        misalign = mem_op && ((is_half && in_lane[0]) ||
                              ((in_funct3 == 3'b010) && (in_lane != 2'b00)));
    end
`else
    assign misalign = 1'b0;
`endif

    // Store byte enables and lane-replicated write data; loads use all lanes
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = '0;
        if (in_mem_write) begin
            case (in_funct3)
                3'b000: begin
                    st_be    = 4'b0001 << in_lane;
                    st_wdata = {4{in_store_data[7:0]}};
                end
                3'b001: begin
                    st_be    = in_lane[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{in_store_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = in_store_data;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension of the returned word
    always_comb begin
        case (op_alu_q[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = op_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_sign = 1'b0;
        case (f3_q[1:0])
            2'b00: begin
                ld_sign = ~f3_q[2] & ld_byte[7];
                ld_data = {{(DATA_WIDTH-8){ld_sign}}, ld_byte};
            end
            2'b01: begin
                ld_sign = ~f3_q[2] & ld_half[15];
                ld_data = {{(DATA_WIDTH-16){ld_sign}}, ld_half};
            end
            default: ld_data = dmem_rdata;
        endcase
    end

    // Next-state, bus request and writeback register computation
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        op_alu_d   = op_alu_q;
        op_rd_d    = op_rd_q;
        op_web_d   = op_web_q;
        op_m2r_d   = op_m2r_q;
        kill_d     = kill_q;
        wb_valid_d = 1'b0;
        wb_web_d   = 1'b0;
        wb_rd_d    = '0;
        wb_m2r_d   = wb_m2r_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
`ifdef MEM_MISALIGN_CHK_EN
        wb_mis_d   = wb_mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    if (mem_op && !misalign) begin
                        state_d  = S_REQ;
                        req_d    = 1'b1;
                        we_d     = in_mem_write;
                        addr_d   = {in_alu_result[DATA_WIDTH-1:2], 2'b00};
                        be_d     = st_be;
                        wdata_d  = st_wdata;
                        f3_d     = in_funct3;
                        op_alu_d = in_alu_result;
                        op_rd_d  = in_rd;
                        op_web_d = in_reg_web;
                        op_m2r_d = in_mem_to_reg;
                        kill_d   = 1'b0;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_m2r_d   = in_mem_to_reg;
                        wb_rd_d    = in_rd;
                        wb_alu_d   = in_alu_result;
                        wb_web_d   = in_reg_web & ~misalign;
                        wb_rdata_d = '0;
`ifdef MEM_MISALIGN_CHK_EN
                        wb_mis_d   = misalign;
`endif
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    // A flushed transaction completes on the bus but never retires
                    if (!(kill_q || flush)) begin
                        wb_valid_d = 1'b1;
                        wb_m2r_d   = op_m2r_q;
                        wb_rd_d    = op_rd_q;
                        wb_alu_d   = op_alu_q;
                        wb_web_d   = op_web_q;
                        wb_rdata_d = we_q ? '0 : ld_data;
`ifdef MEM_MISALIGN_CHK_EN
                        wb_mis_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            op_alu_q   <= '0;
            op_rd_q    <= '0;
            op_web_q   <= 1'b0;
            op_m2r_q   <= 1'b0;
            kill_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_alu_q   <= '0;
            wb_web_q   <= 1'b0;
            wb_rdata_q <= '0;
`ifdef MEM_MISALIGN_CHK_EN
            wb_mis_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            op_alu_q   <= op_alu_d;
            op_rd_q    <= op_rd_d;
            op_web_q   <= op_web_d;
            op_m2r_q   <= op_m2r_d;
            kill_q     <= kill_d;
            wb_valid_q <= wb_valid_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rd_q    <= wb_rd_d;
            wb_alu_q   <= wb_alu_d;
            wb_web_q   <= wb_web_d;
            wb_rdata_q <= wb_rdata_d;
`ifdef MEM_MISALIGN_CHK_EN
            wb_mis_q   <= wb_mis_d;
`endif
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_rd         = wb_rd_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_reg_web    = wb_web_q;
    assign wb_mem_rdata  = wb_rdata_q;
`ifdef MEM_MISALIGN_CHK_EN
    assign wb_misalign   = wb_mis_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access against a
// transaction-level reference model (load/store rules computed arithmetically).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_web, in_mem_to_reg, flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_mem_to_reg, wb_reg_web;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_mem_rdata;
`ifdef MEM_MISALIGN_CHK_EN
    logic        wb_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the values the writeback registers hold between retirements
    logic [31:0] m_alu   = '0;
    logic [31:0] m_rdata = '0;
    logic        m_m2r   = 1'b0;
    logic        m_mis   = 1'b0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .in_reg_web(in_reg_web), .in_mem_to_reg(in_mem_to_reg),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_reg_web(wb_reg_web),
        .wb_mem_rdata(wb_mem_rdata)
`ifdef MEM_MISALIGN_CHK_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3[1:0])
            2'b00: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic exp_mis(input logic rd_op, input logic wr_op,
                                     input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_MISALIGN_CHK_EN
        logic half;
        if (!(rd_op || wr_op)) return 1'b0;
        half = wr_op ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        return (half && a[0]) || (f3 == 3'b010 && a != 2'b00);
`else
        return 1'b0 & rd_op & wr_op & f3[0] & a[0];
`endif
    endfunction

    // Compare all writeback outputs against the model
    task automatic check_wb(input string tag, input logic v, input logic [4:0] rd,
                            input logic web);
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'(v));
        check_eq({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        check_eq({tag, "_wb_reg_web"}, 32'(wb_reg_web), 32'(web));
        check_eq({tag, "_wb_alu"}, wb_alu_result, m_alu);
        check_eq({tag, "_wb_m2r"}, 32'(wb_mem_to_reg), 32'(m_m2r));
        check_eq({tag, "_wb_rdata"}, wb_mem_rdata, m_rdata);
`ifdef MEM_MISALIGN_CHK_EN
        check_eq({tag, "_wb_misalign"}, 32'(wb_misalign), 32'(m_mis));
`endif
    endtask

    // One instruction from accept to retirement; entered and left just after a negedge
    task automatic do_op(input string tag, input logic rd_op, input logic wr_op,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic web, input logic m2r,
                         input int lat, input int flush_at, input logic [31:0] rdata);
        logic        mis, killed;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        mis = exp_mis(rd_op, wr_op, f3, alu[1:0]);
        check_eq({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_mem_read = rd_op; in_mem_write = wr_op; in_funct3 = f3;
        in_alu_result = alu; in_store_data = sdata; in_rd = rd;
        in_reg_web = web; in_mem_to_reg = m2r; flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        if (!(rd_op || wr_op) || mis) begin
            m_alu = alu; m_m2r = m2r; m_rdata = '0; m_mis = mis;
            check_eq({tag, "_no_req"}, 32'(dmem_req), 32'd0);
            check_wb(tag, 1'b1, rd, web & ~mis);
            return;
        end
        if (wr_op && f3 == 3'b000) begin
            e_be = 4'(1 << alu[1:0]); e_wd = 32'(sdata[7:0]) * 32'h0101_0101;
        end else if (wr_op && f3 == 3'b001) begin
            e_be = 4'(3 << (2 * alu[1])); e_wd = 32'(sdata[15:0]) * 32'h0001_0001;
        end else begin
            e_be = 4'hF; e_wd = sdata;
        end
        killed = 1'b0;
        for (int i = 0; i <= lat; i++) begin
            check_eq({tag, "_req"}, 32'(dmem_req), 32'd1);
            check_eq({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
            check_eq({tag, "_addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
            check_eq({tag, "_we"}, 32'(dmem_we), 32'(wr_op));
            check_eq({tag, "_be"}, 32'(dmem_be), 32'(e_be));
            if (wr_op) check_eq({tag, "_wdata"}, dmem_wdata, e_wd);
            check_eq({tag, "_no_wb_in_req"}, 32'(wb_valid), 32'd0);
            if (i == flush_at) begin flush = 1'b1; killed = 1'b1; end
            if (i == lat) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            else dmem_rdata = $urandom;
            @(negedge clk);
            flush = 1'b0; dmem_ack = 1'b0;
        end
        check_eq({tag, "_req_done"}, 32'(dmem_req), 32'd0);
        check_eq({tag, "_ready_done"}, 32'(in_ready), 32'd1);
        if (killed) begin
            check_wb({tag, "_flushed"}, 1'b0, 5'd0, 1'b0);
        end else begin
            m_alu = alu; m_m2r = m2r; m_mis = 1'b0;
            m_rdata = wr_op ? 32'd0 : exp_load(f3, alu[1:0], rdata);
            check_wb(tag, 1'b1, rd, web);
        end
    endtask

    // Cycle with nothing accepted: optional flushed valid and stray ack
    task automatic idle_cycle(input logic vf, input logic stray_ack);
        in_valid = vf; flush = vf; dmem_ack = stray_ack;
        in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
        in_funct3 = 3'($urandom); in_alu_result = $urandom; in_rd = 5'($urandom);
        in_reg_web = 1'b1; in_mem_to_reg = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; dmem_ack = 1'b0;
        check_eq("idle_req", 32'(dmem_req), 32'd0);
        check_eq("idle_ready", 32'(in_ready), 32'd1);
        check_wb("idle", 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_funct3 = '0; in_alu_result = '0; in_store_data = '0; in_rd = '0;
        in_reg_web = 1'b0; in_mem_to_reg = 1'b0; flush = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_wb("rst", 1'b0, 5'd0, 1'b0);
        rst = 1'b0;

        // ADD-type op while ack is held high
        do_op("add", 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, -1, 32'h0);
        dmem_ack = 1'b0;
        do_op("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 3, -1, 32'h80FF_0011);
        check_eq("lb_value", wb_mem_rdata, 32'hFFFF_FF80);
        do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 3, -1, 32'h80FF_0011);
        check_eq("lbu_value", wb_mem_rdata, 32'h0000_0080);
        do_op("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1, -1, 32'h0);
        check_eq("sh_be", 32'(dmem_be), 32'hC);
        check_eq("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        do_op("lh_flush", 1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 2, 0, 32'h1234_5678);
        do_op("lw_flush_ack", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd10, 1'b1, 1'b1, 1, 1, 32'h5);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b1);
        do_op("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd11, 1'b1, 1'b1, 0, -1, 32'hCAFE_F00D);

        // Reset while a request is outstanding
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_alu_result = 32'h40;
        in_rd = 5'd3; in_reg_web = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_mem_read = 1'b0;
        check_eq("rstreq_req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_alu = '0; m_rdata = '0; m_m2r = 1'b0; m_mis = 1'b0;
        check_eq("rstreq_req", 32'(dmem_req), 32'd0);
        check_eq("rstreq_ready", 32'(in_ready), 32'd1);
        check_wb("rstreq", 1'b0, 5'd0, 1'b0);

        // Randomized mix of operations, flushes, latencies and idle cycles
        for (int n = 0; n < 400; n++) begin
            int kind, lat, fa;
            kind = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, 3));
            fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat)) : -1;
            if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom), 1'($urandom));
            do_op("rnd", kind == 1, kind == 2, 3'($urandom), $urandom, $urandom,
                  5'($urandom), 1'($urandom), 1'($urandom), lat, fa, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
